// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e      : FSM encoding (RUN / MEM_WAIT / MD_WAIT)
//   hazard_e     : resolved hazard class; larger value wins
//   REG_X0       : architectural zero register, never a real dependency
//   pick_hazard  : priority resolution of the raw hazard terms
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  // Numeric order mirrors priority: memory wait beats mul/div wait beats
  // redirect beats load-use.
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_LU       = 3'd1,
    HZ_REDIRECT = 3'd2,
    HZ_MDW      = 3'd3,
    HZ_MEMW     = 3'd4
  } hazard_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic hazard_e pick_hazard(input logic memw, input logic mdw,
                                          input logic redirect, input logic lu);
    if (memw)          return HZ_MEMW;
    else if (mdw)      return HZ_MDW;
    else if (redirect) return HZ_REDIRECT;
    else if (lu)       return HZ_LU;
    else               return HZ_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// wait_timer: cycle counter for the data-memory wait.
//   clk, rst   : clock and synchronous active-high reset
//   clr_i      : clear to zero (has priority over en_i)
//   en_i       : count up by one
//   expired_o  : count has reached MEM_TIMEOUT-1
module wait_timer #(
  parameter int TMR_W       = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// Inputs : ID source registers and their use flags, EX load/mul-div/redirect
//          status, MEM data-memory request and acknowledge.
// Outputs: write enables and flushes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB,
//          a one-cycle bus_err pulse on data-memory timeout and a free-running
//          count of stalled (pc_wr_en=0) non-reset cycles.
// Controls are combinational so a stall takes effect in the cycle the
// hazard is seen; only state, timer, bus_err and the counter are registered.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_reg1_addr,
  input  logic [4:0]        rs_reg2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_ex_mem_rd,
  input  logic [4:0]        id_ex_wb_addr,
  input  logic              id_ex_md_op,
  input  logic              md_done,
  input  logic              ex_redirect,
  input  logic              ex_mem_mem_req,
  input  logic              dmem_ack,
  output logic              pc_wr_en,
  output logic              if_id_wr_en,
  output logic              if_id_flush,
  output logic              id_ex_wr_en,
  output logic              id_ex_flush,
  output logic              ex_mem_wr_en,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              bus_err,
  output logic [PERF_W-1:0] stall_cycles
);

  state_e            state_q, state_d;
  logic [PERF_W-1:0] stall_q;
  logic              bus_err_q;
  logic              memw, mdw, lu, expired, abort;
  logic [4:0]        rs_addr [2];
  logic [1:0]        rs_used;
  logic [1:0]        rs_hit;
  hazard_e           hz;

  assign rs_addr[0] = rs_reg1_addr;
  assign rs_addr[1] = rs_reg2_addr;
  assign rs_used    = {id_rs2_used, id_rs1_used};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rs_cmp
      assign rs_hit[gi] = rs_used[gi] & (rs_addr[gi] == id_ex_wb_addr);
    end
  endgenerate

  assign memw = ex_mem_mem_req & ~dmem_ack;
  assign mdw  = id_ex_md_op & ~md_done;
  assign lu   = id_ex_mem_rd & (id_ex_wb_addr != REG_X0) & (|rs_hit);

  // Timeout: the stuck access is retired this cycle instead of stalling
  // again, so the pipeline advances with the MEM/WB slot turned into a NOP.
  assign abort = (state_q == MEM_WAIT) & memw & expired;
  assign hz    = pick_hazard(memw & ~abort, mdw, ex_redirect, lu);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (memw)     state_d = MEM_WAIT;
        else if (mdw) state_d = MD_WAIT;
      end
      MEM_WAIT: begin
        if (!memw || abort) state_d = RUN;
      end
      MD_WAIT: begin
        // The older instruction in MEM takes precedence over the mul/div.
        if (memw)      state_d = MEM_WAIT;
        else if (!mdw) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wr_en  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_wr_en = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_wr_en  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_wr_en = 1'b0;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (hz)
        HZ_MEMW: begin
          // Whole pipe frozen; the WB bubble stops the last writer from
          // writing twice.
          pc_wr_en     = 1'b0;
          if_id_wr_en  = 1'b0;
          id_ex_wr_en  = 1'b0;
          ex_mem_wr_en = 1'b0;
          mem_wb_flush = 1'b1;
        end
        HZ_MDW: begin
          // Front end and EX held; a bubble drains into MEM.
          pc_wr_en     = 1'b0;
          if_id_wr_en  = 1'b0;
          id_ex_wr_en  = 1'b0;
          ex_mem_flush = 1'b1;
        end
        HZ_REDIRECT: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        HZ_LU: begin
          pc_wr_en    = 1'b0;
          if_id_wr_en = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
      if (abort) mem_wb_flush = 1'b1;
    end
  end

  wait_timer #(
    .TMR_W       (TMR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .en_i      (state_q == MEM_WAIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      stall_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= abort;
      if (!pc_wr_en) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus_err      = bus_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 3;

  // Control vector order:
  // {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl, memwb_fl}
  localparam logic [7:0] C_RESET = 8'b0_0_1_0_1_0_1_1;
  localparam logic [7:0] C_NONE  = 8'b1_1_0_1_0_1_0_0;
  localparam logic [7:0] C_MEMW  = 8'b0_0_0_0_0_0_0_1;
  localparam logic [7:0] C_MDW   = 8'b0_0_0_0_0_1_1_0;
  localparam logic [7:0] C_REDIR = 8'b1_1_1_1_1_1_0_0;
  localparam logic [7:0] C_LU    = 8'b0_0_0_1_1_1_0_0;
  localparam logic [7:0] C_ABORT = 8'b1_1_0_1_0_1_0_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_reg1_addr, rs_reg2_addr, id_ex_wb_addr;
  logic        id_rs1_used, id_rs2_used, id_ex_mem_rd, id_ex_md_op, md_done;
  logic        ex_redirect, ex_mem_mem_req, dmem_ack;
  logic        pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush;
  logic        ex_mem_wr_en, ex_mem_flush, mem_wb_flush, bus_err;
  logic [31:0] stall_cycles;
  logic [7:0]  ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush,
                ex_mem_wr_en, ex_mem_flush, mem_wb_flush};

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TIMEOUT),
    .TMR_W       (2),
    .PERF_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs_reg1_addr   (rs_reg1_addr),
    .rs_reg2_addr   (rs_reg2_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_ex_mem_rd   (id_ex_mem_rd),
    .id_ex_wb_addr  (id_ex_wb_addr),
    .id_ex_md_op    (id_ex_md_op),
    .md_done        (md_done),
    .ex_redirect    (ex_redirect),
    .ex_mem_mem_req (ex_mem_mem_req),
    .dmem_ack       (dmem_ack),
    .pc_wr_en       (pc_wr_en),
    .if_id_wr_en    (if_id_wr_en),
    .if_id_flush    (if_id_flush),
    .id_ex_wr_en    (id_ex_wr_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_wr_en   (ex_mem_wr_en),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_flush   (mem_wb_flush),
    .bus_err        (bus_err),
    .stall_cycles   (stall_cycles)
  );

  task automatic clear_inputs();
    rs_reg1_addr = 5'd0; rs_reg2_addr = 5'd0; id_ex_wb_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_ex_mem_rd = 1'b0;
    id_ex_md_op = 1'b0; md_done = 1'b0; ex_redirect = 1'b0;
    ex_mem_mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_ex_mem_rd = 1'b1; id_ex_wb_addr = rd;
    rs_reg1_addr = rd;   id_rs1_used = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_RESET) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 32'd0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: stall=%0d bus_err=%b want 0/0", stall_cycles, bus_err);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", ctl, C_NONE);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    n_tests++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL lu_stall: got %b want %b", ctl, C_LU);
    end
    tick();
    id_ex_mem_rd = 1'b0;
    #1;
    n_tests++;
    if (ctl !== C_NONE || stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL lu_release: ctl=%b stall=%0d want %b/1", ctl, stall_cycles, C_NONE);
    end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_load_x0();
    do_reset();
    set_load_use(5'd0);
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL lu_x0_stall: got %0d want 0", stall_cycles);
    end
    $display("[TB] test_load_x0 done");
  endtask

  task automatic test_muldiv();
    do_reset();
    id_ex_md_op = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_MDW) begin
        n_fail++; $display("FAIL md_wait[%0d]: got %b want %b", i, ctl, C_MDW);
      end
      tick();
    end
    md_done = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL md_done: got %b want %b", ctl, C_NONE);
    end
    tick();
    id_ex_md_op = 1'b0; md_done = 1'b0;
    #1;
    n_tests++;
    if (stall_cycles !== 32'd4) begin
      n_fail++; $display("FAIL md_stall: got %0d want 4", stall_cycles);
    end
    $display("[TB] test_muldiv done");
  endtask

  task automatic test_redirect_lu();
    do_reset();
    set_load_use(5'd7);
    ex_redirect = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_REDIR) begin
      n_fail++; $display("FAIL redir_lu: got %b want %b", ctl, C_REDIR);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL redir_stall: got %0d want 0", stall_cycles);
    end
    $display("[TB] test_redirect_lu done");
  endtask

  task automatic test_mem_timeout();
    do_reset();
    ex_mem_mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      n_tests++;
      if (ctl !== C_MEMW || bus_err !== 1'b0) begin
        n_fail++; $display("FAIL memw[%0d]: ctl=%b bus_err=%b want %b/0", i, ctl, bus_err, C_MEMW);
      end
      tick();
    end
    #1;
    n_tests++;
    if (ctl !== C_ABORT) begin
      n_fail++; $display("FAIL mem_abort: got %b want %b", ctl, C_ABORT);
    end
    tick();
    ex_mem_mem_req = 1'b0;
    #1;
    n_tests++;
    if (bus_err !== 1'b1 || ctl !== C_NONE) begin
      n_fail++; $display("FAIL bus_err_pulse: bus_err=%b ctl=%b want 1/%b", bus_err, ctl, C_NONE);
    end
    tick();
    n_tests++;
    if (bus_err !== 1'b0 || stall_cycles !== 32'(TIMEOUT)) begin
      n_fail++; $display("FAIL bus_err_end: bus_err=%b stall=%0d want 0/%0d", bus_err, stall_cycles, TIMEOUT);
    end
    $display("[TB] test_mem_timeout done");
  endtask

  task automatic test_mem_ack_redirect();
    do_reset();
    ex_mem_mem_req = 1'b1; dmem_ack = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_NONE) begin
      n_fail++; $display("FAIL ack_same_cycle: got %b want %b", ctl, C_NONE);
    end
    tick();
    // Redirect held in the frozen EX stage acts on release.
    dmem_ack = 1'b0; ex_redirect = 1'b1;
    tick();
    tick();
    dmem_ack = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_REDIR || stall_cycles !== 32'd2) begin
      n_fail++; $display("FAIL held_redirect: ctl=%b stall=%0d want %b/2", ctl, stall_cycles, C_REDIR);
    end
    $display("[TB] test_mem_ack_redirect done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ex_mem_mem_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ctl !== C_RESET) begin
      n_fail++; $display("FAIL rst_mid_ctl: got %b want %b", ctl, C_RESET);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (stall_cycles !== 32'd0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_regs: stall=%0d bus_err=%b want 0/0", stall_cycles, bus_err);
    end
    // A fresh wait after reset must again last the full timeout.
    for (int i = 0; i < TIMEOUT; i++) begin
      n_tests++;
      if (ctl !== C_MEMW) begin
        n_fail++; $display("FAIL rst_mid_wait[%0d]: got %b want %b", i, ctl, C_MEMW);
      end
      tick();
    end
    n_tests++;
    if (ctl !== C_ABORT) begin
      n_fail++; $display("FAIL rst_mid_abort: got %b want %b", ctl, C_ABORT);
    end
    tick();
    ex_mem_mem_req = 1'b0;
    $display("[TB] test_reset_mid done");
  endtask

  // Reference model: "streak" counts consecutive cycles the current memory
  // access has already been stalled; once it reaches TIMEOUT the access is
  // abandoned. Outputs follow the hazard priority rules directly.
  task automatic test_random();
    int          streak = 0;
    logic        m_bus = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic        memw, mdw, lu, abort;
    logic [7:0]  exp_ctl;
    int          cyc_fail = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 149) == 0);
      rs_reg1_addr   = 5'($urandom_range(0, 3));
      rs_reg2_addr   = 5'($urandom_range(0, 3));
      id_ex_wb_addr  = 5'($urandom_range(0, 3));
      id_rs1_used    = 1'($urandom_range(0, 1));
      id_rs2_used    = 1'($urandom_range(0, 1));
      id_ex_mem_rd   = 1'($urandom_range(0, 1));
      id_ex_md_op    = ($urandom_range(0, 3) == 0);
      md_done        = ($urandom_range(0, 2) == 0);
      ex_redirect    = ($urandom_range(0, 4) == 0);
      ex_mem_mem_req = ($urandom_range(0, 2) == 0);
      dmem_ack       = ($urandom_range(0, 3) == 0);
      #1;
      memw  = ex_mem_mem_req && !dmem_ack;
      mdw   = id_ex_md_op && !md_done;
      lu    = id_ex_mem_rd && (id_ex_wb_addr != 5'd0) &&
              ((id_rs1_used && rs_reg1_addr == id_ex_wb_addr) ||
               (id_rs2_used && rs_reg2_addr == id_ex_wb_addr));
      abort = memw && (streak == TIMEOUT);
      if (rst)                 exp_ctl = C_RESET;
      else if (memw && !abort) exp_ctl = C_MEMW;
      else if (mdw)            exp_ctl = C_MDW;
      else if (ex_redirect)    exp_ctl = C_REDIR;
      else if (lu)             exp_ctl = C_LU;
      else                     exp_ctl = C_NONE;
      if (abort && !rst) exp_ctl[0] = 1'b1;
      n_tests++;
      if (ctl !== exp_ctl || bus_err !== m_bus || stall_cycles !== m_stall) begin
        n_fail++; cyc_fail++;
        $display("FAIL random[%0d]: ctl=%b bus_err=%b stall=%0d want %b/%b/%0d",
                 c, ctl, bus_err, stall_cycles, exp_ctl, m_bus, m_stall);
      end
      tick();
      if (rst) begin
        streak = 0; m_bus = 1'b0; m_stall = 32'd0;
      end else begin
        m_bus  = abort;
        streak = (memw && !abort) ? streak + 1 : 0;
        if (!exp_ctl[7]) m_stall = m_stall + 32'd1;
      end
    end
    rst = 1'b0;
    clear_inputs();
    $display("[TB] test_random done, %0d cycle mismatches", cyc_fail);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_x0();
    test_muldiv();
    test_redirect_lu();
    test_mem_timeout();
    test_mem_ack_redirect();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
